// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding, port identifiers,
// and the full-word byte mask that reads drive onto the memory port.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  typedef enum logic {
    ARB_PORT_I,
    ARB_PORT_D
  } arb_port_t;

  localparam logic [3:0] ARB_BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Watchdog for an outstanding memory transaction: a saturating counter of
// cycles spent waiting for the memory to respond, and a sticky error flag.
//  clk   in  clock, rising edge
//  rst_n in  asynchronous active-low reset
//  clr   in  restart the count (start of a new transaction)
//  run   in  one more cycle waited without a response
//  err   out sticky: count reached WDOG_CYC (never set when WDOG_CYC == 0)
module mem_port_arbiter_watchdog #(
  parameter int unsigned WDOG_CYC = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic err
);

  localparam int unsigned CW = (WDOG_CYC > 0) ? $clog2(WDOG_CYC + 1) : 1;
  localparam logic [CW-1:0] LIM    = CW'(WDOG_CYC);
  localparam logic [CW-1:0] LIM_M1 = CW'((WDOG_CYC > 0) ? WDOG_CYC - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Counter stops at LIM; the flag sets on the increment that reaches LIM.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && (WDOG_CYC != 0) && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LIM_M1) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the MEM stage
// (load/store). One transaction outstanding; requesters hold until a resp pulse.
//  clk, rst_n                  clock / asynchronous active-low reset
//  i_read, i_addr              fetch request;  i_resp, i_rdata  fetch completion
//  d_read, d_write, d_addr,
//  d_wdata, d_byte_enable      load/store request;  d_resp, d_rdata  completion
//  mem_read, mem_write, mem_addr,
//  mem_wdata, mem_byte_enable  registered memory command
//  mem_resp, mem_rdata         memory completion
//  wdog_err                    sticky: memory failed to respond within WDOG_CYC
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned WDOG_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_byte_enable,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_byte_enable,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wdog_err
);

  arb_state_t        state_q, state_d;
  arb_port_t         rr_last_q, rr_last_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              d_req, take_d, wd_clr, wd_run;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    i_rdata     = '0;
    d_rdata     = '0;
    wd_clr      = 1'b0;
    d_req       = d_read | d_write;
    // Data port wins unless fetch also requests, round-robin is on, and data went last.
    take_d      = d_req && (!i_read || !RR_EN || (rr_last_q == ARB_PORT_I));

    unique case (state_q)
      ARB_IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (take_d) begin
          state_d     = ARB_SERVE_D;
          rr_last_d   = ARB_PORT_D;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // read+write together is treated as a store
          mem_write_d = d_write;
          mem_read_d  = !d_write;
          mem_be_d    = d_write ? d_byte_enable : ARB_BE_FULL;
          wd_clr      = 1'b1;
        end else if (i_read) begin
          state_d     = ARB_SERVE_I;
          rr_last_d   = ARB_PORT_I;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_read_d  = 1'b1;
          mem_be_d    = ARB_BE_FULL;
          wd_clr      = 1'b1;
        end
      end
      ARB_SERVE_I: begin
        if (mem_resp) begin
          i_resp      = 1'b1;
          i_rdata     = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ARB_IDLE;
        end
      end
      ARB_SERVE_D: begin
        if (mem_resp) begin
          d_resp      = 1'b1;
          d_rdata     = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_last_q   <= ARB_PORT_I;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign wd_run = (state_q != ARB_IDLE) && !mem_resp;

  mem_port_arbiter_watchdog #(
    .WDOG_CYC(WDOG_CYC)
  ) u_wdog (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (wd_clr),
    .run  (wd_run),
    .err  (wdog_err)
  );

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a (round-robin, WDOG_CYC=8) and
// instance b (fixed priority, WDOG_CYC=8) share all inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read, d_read, d_write, mem_resp;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;

  logic        a_i_resp, a_d_resp, a_mrd, a_mwr, a_wdog;
  logic [31:0] a_i_rdata, a_d_rdata, a_maddr, a_mwdata;
  logic [3:0]  a_mbe;
  logic        b_i_resp, b_d_resp, b_mrd, b_mwr, b_wdog;
  logic [31:0] b_i_rdata, b_d_rdata, b_maddr, b_mwdata;
  logic [3:0]  b_mbe;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1), .WDOG_CYC(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_resp(a_i_resp), .i_rdata(a_i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_be), .d_resp(a_d_resp), .d_rdata(a_d_rdata),
    .mem_read(a_mrd), .mem_write(a_mwr), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_byte_enable(a_mbe), .mem_resp(mem_resp), .mem_rdata(mem_rdata), .wdog_err(a_wdog)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0), .WDOG_CYC(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_resp(b_i_resp), .i_rdata(b_i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_be), .d_resp(b_d_resp), .d_rdata(b_d_rdata),
    .mem_read(b_mrd), .mem_write(b_mwr), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_byte_enable(b_mbe), .mem_resp(mem_resp), .mem_rdata(mem_rdata), .wdog_err(b_wdog)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Waits from an IDLE-state negedge for instance a to raise a memory strobe.
  task automatic wait_strobe(input string name, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (a_mrd || a_mwr) begin
        ok = 1'b1;
        n  = k;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: strobe got 0 expected 1 within 6 cycles", name);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        i_rd, d_rd, d_wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int unsigned dly;
    logic        exp_rd, exp_wr;
    logic [3:0]  exp_be;
    logic        exp_ir, exp_dr;
  } vec_t;

  typedef struct {
    logic        ir, dr;
    logic [31:0] rdata;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  vec_t        vecs[5];

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at 300us");
    $fatal(1);
  end

  initial begin
    int    n;
    bit    ok;
    resp_t r;
    logic [31:0] ea, eb;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, 4'h0, 32'h0000_0013, 2,
                1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h0000_0055, 3,
                1'b0, 1'b1, 4'b0011, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'h1111_2222, 4'b0001, 32'hCAFE_F00D, 1,
                1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0308, 32'h1234_5678, 4'b1100, 32'h0000_00AA, 2,
                1'b0, 1'b1, 4'b1100, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0404, 32'h0, 4'h0, 32'h8765_4321, 5,
                1'b1, 1'b0, 4'hF, 1'b1, 1'b0};

    do_reset();
    @(negedge clk);
    chk1("rst_mem_read", a_mrd, 1'b0);
    chk1("rst_mem_write", a_mwr, 1'b0);
    chk32("rst_mem_addr", a_maddr, 32'h0);
    chk32("rst_mem_wdata", a_mwdata, 32'h0);
    chk32("rst_mem_be", 32'(a_mbe), 32'h0);
    chk1("rst_i_resp", a_i_resp, 1'b0);
    chk1("rst_d_resp", a_d_resp, 1'b0);
    chk1("rst_wdog", a_wdog, 1'b0);

    // memory response while idle is ignored
    mem_resp = 1'b1; mem_rdata = 32'h0000_ABCD;
    #1;
    chk1("idle_resp_i", a_i_resp, 1'b0);
    chk1("idle_resp_d", a_d_resp, 1'b0);
    chk32("idle_rdata_i", a_i_rdata, 32'h0);
    @(negedge clk);
    mem_resp = 1'b0;
    chk1("idle_no_strobe", a_mrd | a_mwr, 1'b0);

    // table-driven single transactions
    foreach (vecs[v]) begin
      @(negedge clk);
      i_read    = vecs[v].i_rd;
      d_read    = vecs[v].d_rd;
      d_write   = vecs[v].d_wr;
      i_addr    = vecs[v].i_rd ? vecs[v].addr : 32'hFFFF_FFF0;
      d_addr    = (vecs[v].d_rd | vecs[v].d_wr) ? vecs[v].addr : 32'hFFFF_FFF0;
      d_wdata   = vecs[v].wdata;
      d_be      = vecs[v].be;
      mem_rdata = vecs[v].rdata;
      wait_strobe($sformatf("v%0d_strobe", v), n, ok);
      if (ok) begin
        chk32($sformatf("v%0d_latency", v), 32'(n), 32'd1);
        sb.push_back('{vecs[v].exp_ir, vecs[v].exp_dr, vecs[v].rdata});
        for (int unsigned k = 0; k < vecs[v].dly; k++) begin
          chk1($sformatf("v%0d_mem_read", v), a_mrd, vecs[v].exp_rd);
          chk1($sformatf("v%0d_mem_write", v), a_mwr, vecs[v].exp_wr);
          chk32($sformatf("v%0d_mem_addr", v), a_maddr, vecs[v].addr);
          chk32($sformatf("v%0d_mem_be", v), 32'(a_mbe), 32'(vecs[v].exp_be));
          if (vecs[v].exp_wr) chk32($sformatf("v%0d_mem_wdata", v), a_mwdata, vecs[v].wdata);
          chk1($sformatf("v%0d_early_resp", v), a_i_resp | a_d_resp, 1'b0);
          chk32($sformatf("v%0d_early_rdata", v), a_i_rdata | a_d_rdata, 32'h0);
          @(negedge clk);
        end
        mem_resp = 1'b1;
        #1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL v%0d_scoreboard: got empty queue expected entry", v);
        end else begin
          r = sb.pop_front();
          chk1($sformatf("v%0d_i_resp", v), a_i_resp, r.ir);
          chk1($sformatf("v%0d_d_resp", v), a_d_resp, r.dr);
          chk32($sformatf("v%0d_i_rdata", v), a_i_rdata, r.ir ? r.rdata : 32'h0);
          chk32($sformatf("v%0d_d_rdata", v), a_d_rdata, r.dr ? r.rdata : 32'h0);
        end
        @(negedge clk);
        mem_resp = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        chk1($sformatf("v%0d_strobe_clear", v), a_mrd | a_mwr, 1'b0);
        chk1($sformatf("v%0d_resp_pulse", v), a_i_resp | a_d_resp, 1'b0);
      end
    end

    // simultaneous requests: a alternates D,I,D,I; b keeps serving D
    do_reset();
    @(negedge clk);
    i_read = 1'b1; i_addr = 32'h0000_0200;
    d_read = 1'b1; d_addr = 32'h0000_0300;
    mem_rdata = 32'h0000_0077;
    exp_a = '{32'h300, 32'h200, 32'h300, 32'h200};
    exp_b = '{32'h300, 32'h300, 32'h300, 32'h300};
    for (int t = 0; t < 4; t++) begin
      wait_strobe($sformatf("tie%0d_strobe", t), n, ok);
      if (!ok) break;
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      chk32($sformatf("tie%0d_rr_addr", t), a_maddr, ea);
      chk32($sformatf("tie%0d_fp_addr", t), b_maddr, eb);
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      chk1($sformatf("tie%0d_rr_d_resp", t), a_d_resp, ea == 32'h300);
      chk1($sformatf("tie%0d_rr_i_resp", t), a_i_resp, ea == 32'h200);
      chk1($sformatf("tie%0d_fp_d_resp", t), b_d_resp, 1'b1);
      chk1($sformatf("tie%0d_fp_i_resp", t), b_i_resp, 1'b0);
      @(negedge clk);
      mem_resp = 1'b0;
    end
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);

    // watchdog: 8 SERVE cycles without a response
    do_reset();
    @(negedge clk);
    d_read = 1'b1; d_addr = 32'h0000_0040;
    wait_strobe("wdog_strobe", n, ok);
    repeat (7) @(negedge clk);
    chk1("wdog_before_limit", a_wdog, 1'b0);
    @(negedge clk);
    chk1("wdog_at_limit", a_wdog, 1'b1);
    mem_resp = 1'b1;
    #1;
    chk1("wdog_late_d_resp", a_d_resp, 1'b1);
    @(negedge clk);
    mem_resp = 1'b0; d_read = 1'b0;
    @(negedge clk);
    chk1("wdog_sticky", a_wdog, 1'b1);

    // reset in the middle of a data transaction, then a stale memory response
    d_read = 1'b1; d_addr = 32'h0000_0080;
    wait_strobe("rstmid_strobe", n, ok);
    @(negedge clk);
    rst_n = 1'b0; d_read = 1'b0;
    #1;
    chk1("rstmid_mem_read", a_mrd, 1'b0);
    chk32("rstmid_mem_addr", a_maddr, 32'h0);
    chk1("rstmid_wdog", a_wdog, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 32'h0000_0099;
    #1;
    chk1("rstmid_i_resp", a_i_resp, 1'b0);
    chk1("rstmid_d_resp", a_d_resp, 1'b0);
    chk32("rstmid_d_rdata", a_d_rdata, 32'h0);
    @(negedge clk);
    mem_resp = 1'b0;
    chk1("rstmid_idle", a_mrd | a_mwr, 1'b0);

    // requester drops early: the transaction still completes with a resp pulse
    i_read = 1'b1; i_addr = 32'h0000_0010; mem_rdata = 32'h0000_0444;
    wait_strobe("drop_strobe", n, ok);
    i_read = 1'b0;
    @(negedge clk);
    chk1("drop_mem_read_held", a_mrd, 1'b1);
    mem_resp = 1'b1;
    #1;
    chk1("drop_i_resp", a_i_resp, 1'b1);
    chk32("drop_i_rdata", a_i_rdata, 32'h0000_0444);
    @(negedge clk);
    mem_resp = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
